// File: rtl/sev_seg_decoder.sv
// Seven-segment display snooper: debounces multiplexed {dig_sel,seg} samples, decodes
// four digits in order into a frame. Optional build macro: SEV_SEG_BLANK_EN (blank digit support).
module sev_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] dig_sel,
    output logic [7:0] data_new,
    output logic [7:0] data_old,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
`ifdef SEV_SEG_BLANK_EN
    output logic [3:0] blank_mask,
`endif
    output logic       overrun
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      exp_q, exp_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [10:0]     sample_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      data_new_q, data_new_d;
    logic [7:0]      data_old_q, data_old_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            overrun_q, overrun_d;
`ifdef SEV_SEG_BLANK_EN
    logic [3:0]      blank_slot_q, blank_slot_d;
    logic [3:0]      blank_mask_q, blank_mask_d;
`endif

    logic [10:0] sample;
    logic        onehot;
    logic        same;
    logic        accept;
    logic [3:0]  nib;
    logic        pat_valid;
    logic        pat_blank;
    logic        complete;

    assign sample = {dig_sel, seg};
    assign onehot = $onehot(dig_sel);
    assign same   = (sample == sample_q);

    // Run length of the current sample; saturates so a long stable hold fires only once.
    always_comb begin
        cnt_d  = 8'd0;
        accept = 1'b0;
        if (onehot) begin
            if (!same) begin
                cnt_d = 8'd1;
            end else if (cnt_q == STABLE) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            accept = (cnt_d == STABLE) && !(same && (cnt_q == STABLE));
        end
    end

    always_comb begin
        nib       = 4'h0;
        pat_valid = 1'b1;
        pat_blank = 1'b0;
        case (seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
`ifdef SEV_SEG_BLANK_EN
            7'h00: pat_blank = 1'b1;
`endif
            default: pat_valid = 1'b0;
        endcase
    end

    // Frame assembly: digits must arrive 0,1,2,3; anything else abandons the frame.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        slot_d   = slot_q;
        err_d    = 1'b0;
        complete = 1'b0;
`ifdef SEV_SEG_BLANK_EN
        blank_slot_d = blank_slot_q;
`endif
        if (accept) begin
            if (!pat_valid) begin
                err_d   = 1'b1;
                state_d = IDLE;
                exp_d   = 2'd0;
                slot_d  = '0;
`ifdef SEV_SEG_BLANK_EN
                blank_slot_d = '0;
`endif
            end else if (state_q == IDLE) begin
                if (dig_sel == 4'b0001) begin
                    slot_d[0] = nib;
                    exp_d     = 2'd1;
                    state_d   = COLLECT;
`ifdef SEV_SEG_BLANK_EN
                    blank_slot_d    = '0;
                    blank_slot_d[0] = pat_blank;
`endif
                end
            end else if (dig_sel == (4'b0001 << exp_q)) begin
                slot_d[exp_q] = nib;
`ifdef SEV_SEG_BLANK_EN
                blank_slot_d[exp_q] = pat_blank;
`endif
                if (exp_q == 2'd3) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    exp_d    = 2'd0;
                end else begin
                    exp_d = exp_q + 2'd1;
                end
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
                exp_d   = 2'd0;
                slot_d  = '0;
`ifdef SEV_SEG_BLANK_EN
                blank_slot_d = '0;
`endif
            end
        end
    end

    // Output holding register; a frame finishing while the old one is unread is dropped.
    always_comb begin
        data_new_d = data_new_q;
        data_old_d = data_old_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
`ifdef SEV_SEG_BLANK_EN
        blank_mask_d = blank_mask_q;
`endif
        if (complete) begin
            if (!valid_q || out_ready) begin
                data_new_d = {slot_d[1], slot_d[0]};
                data_old_d = {slot_d[3], slot_d[2]};
                valid_d    = 1'b1;
`ifdef SEV_SEG_BLANK_EN
                blank_mask_d = blank_slot_d;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_q      <= 2'd0;
            slot_q     <= '0;
            sample_q   <= '0;
            cnt_q      <= 8'd0;
            data_new_q <= 8'h00;
            data_old_q <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SEV_SEG_BLANK_EN
            blank_slot_q <= '0;
            blank_mask_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            slot_q     <= complete ? '0 : slot_d;
            sample_q   <= sample;
            cnt_q      <= cnt_d;
            data_new_q <= data_new_d;
            data_old_q <= data_old_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
`ifdef SEV_SEG_BLANK_EN
            blank_slot_q <= complete ? '0 : blank_slot_d;
            blank_mask_q <= blank_mask_d;
`endif
        end
    end

    assign data_new  = data_new_q;
    assign data_old  = data_old_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
`ifdef SEV_SEG_BLANK_EN
    assign blank_mask = blank_mask_q;
`endif

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Directed testbench for sev_seg_decoder (default build, STABLE_CYCLES = 4).
module tb_sev_seg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic [7:0] data_new;
    logic [7:0] data_old;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       overrun;

    int assertCount = 0;
    int failCount   = 0;

    sev_seg_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .data_new  (data_new),
        .data_old  (data_old),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Drive one sample and hold it for n rising edges; returns 1 time unit after the last edge.
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_sel = d;
        seg     = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame A digits 2,3,4,5 -> data_new 0x32, data_old 0x54
    task automatic sendFrameA();
        applyStimulus(4'b0001, 7'h5B, 4);
        applyStimulus(4'b0010, 7'h4F, 4);
        applyStimulus(4'b0100, 7'h66, 4);
        applyStimulus(4'b1000, 7'h6D, 4);
    endtask

    // Frame B digits 7,F,A,0 -> data_new 0xF7, data_old 0x0A
    task automatic sendFrameB();
        applyStimulus(4'b0001, 7'h07, 4);
        applyStimulus(4'b0010, 7'h71, 4);
        applyStimulus(4'b0100, 7'h77, 4);
        applyStimulus(4'b1000, 7'h3F, 4);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        dig_sel   = 4'b0000;
        seg       = 7'h00;
        @(posedge clk);
        applyStimulus(4'b0000, 7'h00, 2);
        checkOutput("rst_data_new", data_new, 8'h00);
        checkOutput("rst_data_old", data_old, 8'h00);
        checkOutput("rst_valid", {7'd0, out_valid}, 8'd0);
        checkOutput("rst_err", {7'd0, err}, 8'd0);
        checkOutput("rst_overrun", {7'd0, overrun}, 8'd0);
        rst = 1'b0;

        applyStimulus(4'b0001, 7'h5B, 4);
        applyStimulus(4'b0010, 7'h4F, 4);
        applyStimulus(4'b0100, 7'h66, 4);
        checkOutput("a_valid_partial", {7'd0, out_valid}, 8'd0);
        applyStimulus(4'b1000, 7'h6D, 4);
        checkOutput("a_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("a_data_new", data_new, 8'h32);
        checkOutput("a_data_old", data_old, 8'h54);
        checkOutput("a_err", {7'd0, err}, 8'd0);

        out_ready = 1'b1;
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("consume_valid", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;

        applyStimulus(4'b0001, 7'h5B, 8);
        checkOutput("long_hold_err", {7'd0, err}, 8'd0);
        applyStimulus(4'b0010, 7'h4F, 2);
        applyStimulus(4'b0010, 7'h06, 2);
        applyStimulus(4'b0010, 7'h4F, 2);
        applyStimulus(4'b0010, 7'h06, 3);
        checkOutput("toggle_err", {7'd0, err}, 8'd0);
        applyStimulus(4'b0010, 7'h4F, 4);
        applyStimulus(4'b0100, 7'h66, 4);
        applyStimulus(4'b1000, 7'h6D, 4);
        checkOutput("toggle_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("toggle_data_new", data_new, 8'h32);
        checkOutput("toggle_data_old", data_old, 8'h54);
        out_ready = 1'b1;
        applyStimulus(4'b0000, 7'h00, 1);
        out_ready = 1'b0;

        applyStimulus(4'b0001, 7'h3F, 4);
        applyStimulus(4'b0100, 7'h66, 4);
        checkOutput("seq_err_pulse", {7'd0, err}, 8'd1);
        checkOutput("seq_err_valid", {7'd0, out_valid}, 8'd0);
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("seq_err_clear", {7'd0, err}, 8'd0);
        sendFrameB();
        checkOutput("recover_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("recover_data_new", data_new, 8'hF7);
        checkOutput("recover_data_old", data_old, 8'h0A);
        out_ready = 1'b1;
        applyStimulus(4'b0000, 7'h00, 1);
        out_ready = 1'b0;

        applyStimulus(4'b0001, 7'h5B, 4);
        applyStimulus(4'b0010, 7'h4F, 4);
        applyStimulus(4'b0100, 7'h01, 4);
        checkOutput("bad_pat_err", {7'd0, err}, 8'd1);
        checkOutput("bad_pat_valid", {7'd0, out_valid}, 8'd0);
        applyStimulus(4'b0001, 7'h00, 4);
        checkOutput("blank_invalid_err", {7'd0, err}, 8'd1);
        applyStimulus(4'b0000, 7'h00, 1);

        sendFrameA();
        checkOutput("ovr_first_valid", {7'd0, out_valid}, 8'd1);
        sendFrameB();
        checkOutput("ovr_pulse", {7'd0, overrun}, 8'd1);
        checkOutput("ovr_held_new", data_new, 8'h32);
        checkOutput("ovr_held_old", data_old, 8'h54);
        checkOutput("ovr_still_valid", {7'd0, out_valid}, 8'd1);
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("ovr_pulse_end", {7'd0, overrun}, 8'd0);
        out_ready = 1'b1;
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("ready_clears", {7'd0, out_valid}, 8'd0);
        sendFrameB();
        checkOutput("ready_load_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("ready_load_new", data_new, 8'hF7);
        checkOutput("ready_load_ovr", {7'd0, overrun}, 8'd0);
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("ready_clear2", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;

        applyStimulus(4'b0001, 7'h5B, 4);
        applyStimulus(4'b0010, 7'h4F, 4);
        rst = 1'b1;
        applyStimulus(4'b0000, 7'h00, 1);
        rst = 1'b0;
        checkOutput("midrst_new", data_new, 8'h00);
        checkOutput("midrst_old", data_old, 8'h00);
        checkOutput("midrst_valid", {7'd0, out_valid}, 8'd0);
        checkOutput("midrst_err", {7'd0, err}, 8'd0);
        checkOutput("midrst_overrun", {7'd0, overrun}, 8'd0);
        applyStimulus(4'b0100, 7'h66, 4);
        applyStimulus(4'b1000, 7'h6D, 4);
        checkOutput("midrst_no_frame", {7'd0, out_valid}, 8'd0);
        sendFrameA();
        checkOutput("post_rst_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("post_rst_new", data_new, 8'h32);
        checkOutput("post_rst_old", data_old, 8'h54);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sev_seg_decoder.md
SEV_SEG_DECODER -- requirements
Module: sev_seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive identical samples (1..255) needed to accept a digit.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port seg, input, 7, segment pattern, bit0=a ... bit6=g, 1=lit.
REQ-005 SHALL have port dig_sel, input, 4, digit select; bit k one-hot selects digit k.
REQ-006 SHALL have port data_new, output, 8, {digit1,digit0} of the last delivered frame.
REQ-007 SHALL have port data_old, output, 8, {digit3,digit2} of the last delivered frame.
REQ-008 SHALL have port out_valid, output, 1, frame available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts frame.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on an invalid pattern or an out-of-sequence digit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL decode patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F,0x77,0x7C,0x39,0x5E,0x79,0x71 to nibbles 0..F respectively; every other pattern is invalid.
REQ-013 SHALL accept a digit on the single cycle in which {dig_sel,seg} has been unchanged for STABLE_CYCLES consecutive cycles; a continuing stable run SHALL NOT re-accept.
REQ-014 SHALL clear the stability counter when {dig_sel,seg} changes or dig_sel is not one-hot; a non-one-hot dig_sel SHALL never produce an accept.
REQ-015 SHALL implement FSM states IDLE and COLLECT with an expected-index register exp (2 bits).
REQ-016 In IDLE, an accept with dig_sel=0001 and a valid pattern SHALL store slot0, set exp=1 and go to COLLECT; other accepts SHALL be ignored.
REQ-017 In COLLECT, an accept with dig_sel bit exp and a valid pattern SHALL store slot exp and increment exp.
REQ-018 In COLLECT, an accept with any other index SHALL pulse err, discard slots and go to IDLE.
REQ-019 An accept with an invalid pattern SHALL pulse err in the following cycle, discard slots and go to IDLE, in either state.
REQ-020 Storing slot3 SHALL complete the frame and return the FSM to IDLE.
REQ-021 On frame completion, if out_valid=0 or out_ready=1 in that cycle, the outputs SHALL be loaded and out_valid SHALL be 1 in the next cycle; otherwise the frame SHALL be dropped, overrun SHALL pulse, and the held outputs SHALL remain unchanged.
REQ-022 out_valid SHALL clear on a cycle with out_ready=1 unless a frame completes in the same cycle.
REQ-023 data_new and data_old SHALL be stable while out_valid=1.

Reset
REQ-024 rst SHALL force IDLE, exp=0, counter=0, slots=0, data_new=0x00, data_old=0x00, out_valid=0, err=0, overrun=0.
REQ-025 rst asserted mid-frame SHALL discard partial slots, with no err or overrun pulse.

Configuration
REQ-026 Macro SEV_SEG_BLANK_EN defined SHALL treat pattern 0x00 as valid value 0 and add output blank_mask (4 bits, bit k=1 when digit k of the delivered frame was blank, reset 0).
REQ-027 Without SEV_SEG_BLANK_EN, pattern 0x00 SHALL be invalid and blank_mask SHALL NOT exist.

Verification
REQ-028 STABLE_CYCLES=4; each of dig_sel 0001/0010/0100/1000 with seg 0x5B/0x4F/0x66/0x6D held 4 cycles -> data_new=0x32, data_old=0x54, out_valid=1 one cycle after the fourth accept.
REQ-029 Same frame with seg toggling every 2 cycles on digit1 -> no accept until 4 stable cycles; frame still 0x32/0x54.
REQ-030 dig_sel 0001 then 0100 -> err pulse, no out_valid; the next correct frame is delivered normally.
REQ-031 seg 0x01 on digit2 -> err pulse, no out_valid; with SEV_SEG_BLANK_EN, seg 0x00 on digit3 -> data_old high nibble=0, blank_mask=1000.
REQ-032 out_ready=0, two full frames -> first frame held, overrun pulse on second completion; out_ready=1 -> out_valid clears next cycle.
REQ-033 rst asserted after two digits -> all outputs 0; a subsequent full frame decodes correctly.
